denormalizer: RTL and testbench

- Inverse of the single-precision normalizer: maps a normalized IEEE-754 value back to the original range.
- Computes out_data = in_data * (max - min) + min.
- Sits on the ALU output side after model evaluation, reusing the same start/busy/valid handshake as the normalizer so the two are drop-in symmetric.
- Fixed-latency, multi-cycle FSM with one internal add/sub datapath (used twice) and one 24x24 mantissa multiplier.

---
 rtl/denormalizer.sv | 211 +++++++++++++++++++++
 tb/tb_denormalizer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/denormalizer.sv
// denormalizer: out_data = in_data * (max - min) + min in IEEE-754 single
// precision, truncating at every stage. Fixed 8-cycle latency, with one shared
// add/sub datapath (used for the range and for the final offset) and one
// 24x24 mantissa multiplier.
module denormalizer #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        valid,
  input  logic [31:0] max,
  input  logic [31:0] min,
  input  logic [31:0] in_data,
  output logic [31:0] out_data
);

  typedef enum logic [3:0] {
    IDLE, SUB_ALIGN, SUB_ADD, SUB_NORM, MUL, MUL_NORM, ADD_ALIGN, ADD_ADD, ADD_NORM
  } state_t;

  state_t      state_q;
  logic        busy_q, valid_q, nan_q;
  logic [31:0] out_q, max_q, min_q, in_q, range_q, prod_q;

  // Shared adder stage registers
  logic        al_sign_q, al_sub_q, al_inf_q;
  logic [7:0]  al_exp_q;
  logic [26:0] al_big_q, al_small_q;
  logic        ad_sign_q, ad_inf_q;
  logic [7:0]  ad_exp_q;
  logic [27:0] ad_sum_q;

  // Multiplier stage registers (top 25 bits of the 48-bit product)
  logic              mu_sign_q, mu_inf_q, mu_zero_q;
  logic signed [9:0] mu_exp_q;
  logic [24:0]       mu_prod_q;

  // Combinational next-state values
  logic [31:0]       opa, opb;
  logic [26:0]       ma, mb, small_m;
  logic [7:0]        shamt;
  logic              a_big;
  logic              al_sign_d, al_sub_d, al_inf_d;
  logic [7:0]        al_exp_d;
  logic [26:0]       al_big_d, al_small_d;
  logic [27:0]       ad_sum_d;
  logic [4:0]        lzc;
  logic [26:0]       norm_m;
  logic [31:0]       sum_res;
  logic [23:0]       mul_a, mul_b;
  logic [47:0]       mul_full;
  logic              mu_sign_d, mu_inf_d, mu_zero_d;
  logic signed [9:0] mu_exp_d;
  logic [31:0]       prod_res;
  logic              unused_bits;

  // Flush underflow to signed zero, saturate overflow to signed infinity.
  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic [22:0] f);
    if (e <= 10'sd0)        return {s, 31'b0};
    else if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
    else                    return {s, e[7:0], f};
  endfunction

  // Align: order operands by magnitude, shift the smaller one right.
  always_comb begin
    opa        = (state_q == ADD_ALIGN) ? prod_q : max_q;
    opb        = (state_q == ADD_ALIGN) ? min_q  : {~min_q[31], min_q[30:0]};
    ma         = (opa[30:23] == '0) ? '0 : {1'b1, opa[22:0], 3'b000};
    mb         = (opb[30:23] == '0) ? '0 : {1'b1, opb[22:0], 3'b000};
    a_big      = {opa[30:23], ma} >= {opb[30:23], mb};
    al_big_d   = a_big ? ma : mb;
    small_m    = a_big ? mb : ma;
    al_exp_d   = a_big ? opa[30:23] : opb[30:23];
    shamt      = a_big ? (opa[30:23] - opb[30:23]) : (opb[30:23] - opa[30:23]);
    al_small_d = (shamt >= 8'd27) ? '0 : (small_m >> shamt);
    al_sign_d  = a_big ? opa[31] : opb[31];
    al_sub_d   = opa[31] ^ opb[31];
    al_inf_d   = (opa[30:23] == '1) || (opb[30:23] == '1);
  end

  // Add/sub of aligned magnitudes; the larger one is always first.
  always_comb begin
    if (al_sub_q) ad_sum_d = {1'b0, al_big_q} - {1'b0, al_small_q};
    else          ad_sum_d = {1'b0, al_big_q} + {1'b0, al_small_q};
  end

  // Normalize the sum: carry-out shifts right, otherwise leading-zero shift left.
  always_comb begin
    lzc = '0;
    for (int unsigned i = 0; i < 27; i++)
      if (ad_sum_q[i]) lzc = 5'(26 - i);
    norm_m = ad_sum_q[26:0] << lzc;
    if (ad_inf_q)             sum_res = {ad_sign_q, 8'hFF, 23'b0};
    else if (ad_sum_q == '0)  sum_res = '0;
    else if (ad_sum_q[27])    sum_res = pack(ad_sign_q, $signed({2'b00, ad_exp_q}) + 10'sd1,
                                             ad_sum_q[26:4]);
    else                      sum_res = pack(ad_sign_q, $signed({2'b00, ad_exp_q}) -
                                             $signed({5'b0, lzc}), norm_m[25:3]);
  end

  // Mantissa product and biased exponent sum.
  always_comb begin
    mul_a     = {1'b1, in_q[22:0]};
    mul_b     = {1'b1, range_q[22:0]};
    mul_full  = 48'(mul_a) * 48'(mul_b);
    mu_sign_d = in_q[31] ^ range_q[31];
    mu_inf_d  = (in_q[30:23] == '1) || (range_q[30:23] == '1);
    mu_zero_d = (in_q[30:23] == '0) || (range_q[30:23] == '0);
    mu_exp_d  = $signed({2'b00, in_q[30:23]}) + $signed({2'b00, range_q[30:23]}) - 10'sd127;
  end

  // Product normalize: at most one right shift. Infinity wins over zero.
  always_comb begin
    if (mu_inf_q)          prod_res = {mu_sign_q, 8'hFF, 23'b0};
    else if (mu_zero_q)    prod_res = {mu_sign_q, 31'b0};
    else if (mu_prod_q[24]) prod_res = pack(mu_sign_q, mu_exp_q + 10'sd1, mu_prod_q[23:1]);
    else                   prod_res = pack(mu_sign_q, mu_exp_q, mu_prod_q[22:0]);
  end

  assign unused_bits = ^{mul_full[22:0], norm_m[26], norm_m[2:0]};

  // Sequencer: walks all states for every operation, registers outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      nan_q      <= 1'b0;
      out_q      <= '0;
      max_q      <= '0;
      min_q      <= '0;
      in_q       <= '0;
      range_q    <= '0;
      prod_q     <= '0;
      al_sign_q  <= 1'b0;
      al_sub_q   <= 1'b0;
      al_inf_q   <= 1'b0;
      al_exp_q   <= '0;
      al_big_q   <= '0;
      al_small_q <= '0;
      ad_sign_q  <= 1'b0;
      ad_inf_q   <= 1'b0;
      ad_exp_q   <= '0;
      ad_sum_q   <= '0;
      mu_sign_q  <= 1'b0;
      mu_inf_q   <= 1'b0;
      mu_zero_q  <= 1'b0;
      mu_exp_q   <= '0;
      mu_prod_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          max_q   <= max;
          min_q   <= min;
          in_q    <= in_data;
          nan_q   <= (max[30:23] == '1) || (min[30:23] == '1) || (in_data[30:23] == '1);
          busy_q  <= 1'b1;
          state_q <= SUB_ALIGN;
        end
        SUB_ALIGN, ADD_ALIGN: begin
          al_sign_q  <= al_sign_d;
          al_sub_q   <= al_sub_d;
          al_inf_q   <= al_inf_d;
          al_exp_q   <= al_exp_d;
          al_big_q   <= al_big_d;
          al_small_q <= al_small_d;
          state_q    <= (state_q == SUB_ALIGN) ? SUB_ADD : ADD_ADD;
        end
        SUB_ADD, ADD_ADD: begin
          ad_sum_q  <= ad_sum_d;
          ad_sign_q <= al_sign_q;
          ad_exp_q  <= al_exp_q;
          ad_inf_q  <= al_inf_q;
          state_q   <= (state_q == SUB_ADD) ? SUB_NORM : ADD_NORM;
        end
        SUB_NORM: begin
          range_q <= sum_res;
          state_q <= MUL;
        end
        MUL: begin
          mu_sign_q <= mu_sign_d;
          mu_inf_q  <= mu_inf_d;
          mu_zero_q <= mu_zero_d;
          mu_exp_q  <= mu_exp_d;
          mu_prod_q <= mul_full[47:23];
          state_q   <= MUL_NORM;
        end
        MUL_NORM: begin
          prod_q  <= prod_res;
          state_q <= ADD_ALIGN;
        end
        ADD_NORM: begin
          out_q   <= nan_q ? QNAN : sum_res;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_denormalizer.sv
// Scoreboard bench for denormalizer: stimulus pushes expected results with
// their due cycle; a monitor pops and compares on every valid pulse.
module tb_denormalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] max_v = '0, min_v = '0, in_v = '0;
  logic        busy, valid;
  logic [31:0] out_data;

  denormalizer #(.QNAN(32'h7FC00000)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .valid(valid),
    .max(max_v), .min(min_v), .in_data(in_v), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          last_acc = -100;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hold_exp = '0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic logic [31:0] m_pack(bit s, int e, longint f);
    logic [31:0] r;
    if (e <= 0)        r = {s, 31'b0};
    else if (e >= 255) r = {s, 8'hFF, 23'b0};
    else begin
      r[31]    = s;
      r[30:23] = e[7:0];
      r[22:0]  = f[22:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_add(logic [31:0] a, logic [31:0] b);
    logic [31:0] big, sml;
    int          eb, es, d, e;
    longint      mb, ms, s;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    eb = int'(big[30:23]);
    es = int'(sml[30:23]);
    if (eb == 255 || es == 255) return {big[31], 8'hFF, 23'b0};
    mb = (eb == 0) ? 64'sd0 : longint'({1'b1, big[22:0]}) * 8;
    ms = (es == 0) ? 64'sd0 : longint'({1'b1, sml[22:0]}) * 8;
    d  = eb - es;
    ms = (d >= 27) ? 64'sd0 : ms / (longint'(1) << d);
    s  = (big[31] == sml[31]) ? mb + ms : mb - ms;
    if (s == 0) return 32'h0;
    e = eb;
    while (s >= (longint'(1) << 27)) begin s = s / 2; e++; end
    while (s <  (longint'(1) << 26)) begin s = s * 2; e--; end
    return m_pack(big[31], e, (s / 8) % (longint'(1) << 23));
  endfunction

  function automatic logic [31:0] m_mul(logic [31:0] a, logic [31:0] b);
    bit     s;
    int     e;
    longint p;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'b0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (longint'(1) << 47)) begin p = p / 2; e++; end
    return m_pack(s, e, (p / (longint'(1) << 23)) % (longint'(1) << 23));
  endfunction

  function automatic logic [31:0] m_denorm(logic [31:0] mx, logic [31:0] mn, logic [31:0] di);
    if (mx[30:23] == 8'hFF || mn[30:23] == 8'hFF || di[30:23] == 8'hFF) return 32'h7FC00000;
    return m_add(m_mul(di, m_add(mx, {~mn[31], mn[30:0]})), mn);
  endfunction

  function automatic logic [31:0] rnd_fp(int unsigned lo, int unsigned hi, bit pos);
    int unsigned r;
    logic [31:0] v;
    r = $urandom_range(0, 99);
    v = $urandom();
    if (pos) v[31] = 1'b0;
    if (r < 4)       v[30:0]  = '0;
    else if (r < 7)  v[30:23] = 8'hFF;
    else if (r < 9)  v[30:23] = 8'h00;
    else if (r >= 12 && r < 15)
      v[30:23] = 8'(($urandom_range(0, 1) == 1) ? $urandom_range(250, 254) : $urandom_range(1, 4));
    else if (r >= 15) v[30:23] = 8'($urandom_range(lo, hi));
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on valid, checks timing, hold and busy.
  always @(negedge clk) begin : mon
    logic exp_busy;
    if (!rst) begin
      sb.delete();
      hold_exp = '0;
    end
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_valid @cycle %0d: got valid=1 expected no pending result", cyc);
      end else begin
        chk("valid_cycle", 32'(cyc), 32'(sb[0].due));
        chk("out_data", out_data, sb[0].val);
        hold_exp = sb[0].val;
        void'(sb.pop_front());
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid_missing @cycle %0d: got valid=%b expected 1 (due %0d)", cyc, valid, sb[0].due);
        void'(sb.pop_front());
      end
      chk("out_hold", out_data, hold_exp);
    end
    exp_busy = (sb.size() > 0) && (sb[0].due - 8 <= cyc);
    chk("busy", 32'(busy), 32'(exp_busy));
    if (done) begin
      chk("drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(logic [31:0] mx, logic [31:0] mn, logic [31:0] di,
                       bit lit, logic [31:0] lit_val);
    int   c;
    exp_t e;
    @(negedge clk);
    #1;
    max_v = mx;
    min_v = mn;
    in_v  = di;
    start = 1'b1;
    c = cyc + 1;
    if (c > last_acc + 8) begin
      e.val = lit ? lit_val : m_denorm(mx, mn, di);
      e.due = c + 8;
      sb.push_back(e);
      last_acc = c;
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    max_v = $urandom();
    min_v = $urandom();
    in_v  = $urandom();
  endtask

  initial begin
    logic [31:0] mx, mn, di;
    idle(3);
    #1 rst = 1'b1;

    issue(32'h41200000, 32'h40000000, 32'h3F000000, 1, 32'h40C00000); idle(8);
    issue(32'h41200000, 32'h40000000, 32'h00000000, 1, 32'h40000000); idle(8);
    issue(32'h41200000, 32'h40000000, 32'h3F800000, 1, 32'h41200000); idle(8);
    issue(32'h40800000, 32'hC0800000, 32'h3E800000, 1, 32'hC0000000); idle(8);
    issue(32'h40800000, 32'hC0800000, 32'h3F000000, 1, 32'h00000000); idle(8);
    issue(32'h41200000, 32'h40000000, 32'h7F800000, 1, 32'h7FC00000); idle(8);
    issue(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h3F800000, 1, 32'h7F800000); idle(8);

    // second start three cycles after the first is ignored
    issue(32'h40800000, 32'hC0800000, 32'h3F800000, 1, 32'h40800000);
    idle(1);
    issue(32'h41200000, 32'h40000000, 32'h3F000000, 1, 32'h40C00000);
    idle(10);

    // start in the valid cycle is accepted
    issue(32'h41200000, 32'h40000000, 32'h3E800000, 1, 32'h40800000);
    idle(7);
    issue(32'h40800000, 32'hC0800000, 32'h3F000000, 1, 32'h00000000);
    idle(10);

    // asynchronous reset while in MUL, held across one rising edge
    issue(32'h41200000, 32'h40000000, 32'h3F800000, 1, 32'h41200000);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    last_acc = -100;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    idle(12);
    issue(32'h41200000, 32'h40000000, 32'h3F000000, 1, 32'h40C00000);
    idle(10);

    for (int i = 0; i < 250; i++) begin
      mx = rnd_fp(110, 150, 0);
      mn = ($urandom_range(0, 19) == 0) ? mx : rnd_fp(110, 150, 0);
      di = rnd_fp(100, 127, 1);
      idle($urandom_range(0, 10));
      issue(mx, mn, di, 0, 32'h0);
    end
    idle(15);

    @(negedge clk);
    #1 done = 1'b1;
    idle(5);
    $display("FAIL watchdog: got no summary expected monitor to finish");
    $fatal(1);
  end

endmodule
